// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM for the program_counter / instruction_rom /
// branching fetch loop. It boots execution from PC 0, freezes the PC while
// data memory is busy, decodes branch opcodes into strobes for `branching`,
// detects HALT, aborts a stuck stall and counts retired instructions.
module fetch_sequencer #(
  parameter int D           = 12,  // PC width of the surrounding fetch loop
  parameter int STALL_LIMIT = 15   // max consecutive busy cycles (1..255)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  machine_code,
  input  logic        mem_busy,
  output logic        pc_reset,
  output logic        pc_hold,
  output logic        compare_enable,
  output logic        reljump_enable,
  output logic        absjump_enable,
  output logic        running,
  output logic        done,
  output logic        error,
  output logic [15:0] instr_count
);

  // Reject nonsensical parameterisations at elaboration time.
  if (D < 1 || STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_params
    $error("fetch_sequencer: D must be >= 1 and STALL_LIMIT in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOOT,
    S_RUN,
    S_STALL,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  stall_cnt;
  logic [7:0]  stall_cnt_next;
  logic [8:0]  stall_inc;
  logic        stall_abort;
  logic        is_halt;
  logic        is_branch;
  logic        active;
  logic        retire;
  logic        launch;

  // Opcode decode and the shared retire/launch qualifiers.
  assign is_halt   = (machine_code == 9'h1FF);
  assign is_branch = (machine_code[8:6] == 3'b110);
  assign active    = (state == S_RUN) || (state == S_STALL);
  // HALT beats a concurrent mem_busy, so a HALT word never retires.
  assign retire    = active && !mem_busy && !is_halt;
  assign launch    = ((state == S_IDLE) || (state == S_HALT)) && start;

  // Stall counter one step ahead; widened so the limit compare cannot wrap.
  assign stall_inc   = {1'b0, stall_cnt} + 9'd1;
  assign stall_abort = (state == S_STALL) && mem_busy && !is_halt &&
                       (stall_inc > 9'(STALL_LIMIT));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and next stall-count logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_next     = state;
    stall_cnt_next = 8'd0;
    unique case (state)
      S_IDLE: if (start) state_next = S_BOOT;
      S_BOOT: state_next = S_RUN;
      S_RUN: begin
        if (is_halt) begin
          state_next = S_HALT;
        end else if (mem_busy) begin
          state_next     = S_STALL;
          stall_cnt_next = 8'd1;
        end
      end
      S_STALL: begin
        if (is_halt) begin
          state_next = S_HALT;
        end else if (mem_busy) begin
          if (stall_abort) state_next = S_HALT;
          else             stall_cnt_next = stall_inc[7:0];
        end else begin
          state_next = S_RUN;
        end
      end
      S_HALT: if (start) state_next = S_BOOT;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered status: stall counter, done, sticky error, retire count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= 8'd0;
      done        <= 1'b0;
      error       <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      stall_cnt <= stall_cnt_next;
      done      <= (state_next == S_HALT);
      if (launch) begin
        error       <= 1'b0;
        instr_count <= 16'd0;
      end else begin
        if (stall_abort) error <= 1'b1;
        if (retire && (instr_count != 16'hFFFF))
          instr_count <= instr_count + 16'd1;
      end
    end
  end

  // Mealy outputs: PC control and branch strobes, valid with machine_code.
  always_comb begin
    pc_reset       = (state == S_BOOT);
    pc_hold        = !retire;
    running        = active;
    compare_enable = 1'b0;
    reljump_enable = 1'b0;
    absjump_enable = 1'b0;
    if (retire && is_branch) begin
      compare_enable = machine_code[5];
      reljump_enable = machine_code[4];
      absjump_enable = !machine_code[4];
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. A small ROM and a
// program_counter/branching stand-in close the fetch loop around the DUT
// (absolute target = code[3:0], relative offset = signed code[3:0],
// conditional branches always taken).
module tb_fetch_sequencer;

  localparam int D = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  machine_code;
  logic        mem_busy;
  logic        pc_reset;
  logic        pc_hold;
  logic        compare_enable;
  logic        reljump_enable;
  logic        absjump_enable;
  logic        running;
  logic        done;
  logic        error;
  logic [15:0] instr_count;

  logic [8:0]   rom [0:15];
  logic [D-1:0] pc;
  logic [2:0]   strobes;

  int n_checks = 0;
  int n_errors = 0;
  int n_pc_reset = 0;
  int n_abs = 0;
  int n_cmp = 0;
  int n_retire = 0;
  int base_pr, base_abs, base_cmp, base_ret;

  fetch_sequencer #(.D(D), .STALL_LIMIT(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .machine_code   (machine_code),
    .mem_busy       (mem_busy),
    .pc_reset       (pc_reset),
    .pc_hold        (pc_hold),
    .compare_enable (compare_enable),
    .reljump_enable (reljump_enable),
    .absjump_enable (absjump_enable),
    .running        (running),
    .done           (done),
    .error          (error),
    .instr_count    (instr_count)
  );

  always #5 clock = ~clock;

  assign machine_code = rom[pc[3:0]];
  assign strobes      = {compare_enable, reljump_enable, absjump_enable};

  // PC register with branching applied, as the real fetch loop would.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              pc <= '0;
    else if (pc_reset)       pc <= '0;
    else if (!pc_hold) begin
      if (absjump_enable)      pc <= D'(machine_code[3:0]);
      else if (reljump_enable) pc <= pc + {{(D-4){machine_code[3]}}, machine_code[3:0]};
      else                     pc <= pc + 1'b1;
    end
  end

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (pc_reset)             n_pc_reset <= n_pc_reset + 1;
    if (absjump_enable)       n_abs      <= n_abs + 1;
    if (compare_enable)       n_cmp      <= n_cmp + 1;
    if (running && !pc_hold)  n_retire   <= n_retire + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 9'h000;
  endtask

  task automatic snapshot();
    base_pr  = n_pc_reset;
    base_abs = n_abs;
    base_cmp = n_cmp;
    base_ret = n_retire;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; mem_busy = 1'b0;
    clear_rom();
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003;
    rom[3] = 9'h004; rom[4] = 9'h005; rom[5] = 9'h1FF;
    step(2);

    // Reset state
    check("rst_pc_hold",  32'(pc_hold), 32'd1);
    check("rst_pc_reset", 32'(pc_reset), 32'd0);
    check("rst_running",  32'(running), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_error",    32'(error), 32'd0);
    check("rst_count",    32'(instr_count), 32'd0);
    check("rst_strobes",  32'(strobes), 32'd0);
    reset = 1'b1;
    step(1);

    // Five ordinary words then HALT
    snapshot();
    start = 1'b1; step(1); start = 1'b0;
    check("boot_pc_reset", 32'(pc_reset), 32'd1);
    check("boot_running",  32'(running), 32'd0);
    step(9);
    check("p1_pc_reset_pulses", 32'(n_pc_reset - base_pr), 32'd1);
    check("p1_retires",    32'(n_retire - base_ret), 32'd5);
    check("p1_done",       32'(done), 32'd1);
    check("p1_count",      32'(instr_count), 32'd5);
    check("p1_pc",         32'(pc), 32'd5);
    check("p1_pc_hold",    32'(pc_hold), 32'd1);
    check("p1_running",    32'(running), 32'd0);

    // Absolute branch at PC 3 back to 0
    clear_rom();
    rom[0] = 9'h010; rom[1] = 9'h020; rom[2] = 9'h030;
    rom[3] = 9'h180; rom[6] = 9'h1FF;
    snapshot();
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    check("abs_strobes_2pass", 32'(n_abs - base_abs), 32'd2);
    check("abs_compare",       32'(n_cmp - base_cmp), 32'd0);
    check("abs_count_2pass",   32'(instr_count), 32'd8);
    check("abs_pc",            32'(pc), 32'd0);
    check("abs_done",          32'(done), 32'd0);
    step(4);
    check("abs_strobes_3pass", 32'(n_abs - base_abs), 32'd3);
    check("abs_count_3pass",   32'(instr_count), 32'd12);
    check("abs_running",       32'(running), 32'd1);

    // Conditional relative branch (+2) at PC 1
    reset = 1'b0; step(1); reset = 1'b1;
    clear_rom();
    rom[0] = 9'h005; rom[1] = 9'h1B2; rom[2] = 9'h007; rom[3] = 9'h1FF;
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    check("rel_first_pc",   32'(pc), 32'd0);
    check("rel_first_hold", 32'(pc_hold), 32'd0);
    step(1);
    check("rel_strobes",    32'(strobes), 32'b110);
    step(4);
    check("rel_done",  32'(done), 32'd1);
    check("rel_pc",    32'(pc), 32'd3);
    check("rel_count", 32'(instr_count), 32'd2);

    // Three busy cycles on an absolute branch word
    clear_rom();
    rom[0] = 9'h00A; rom[1] = 9'h184; rom[4] = 9'h1FF;
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pc_hold", 32'(pc_hold), 32'd1);
      check("stall_strobes", 32'(strobes), 32'd0);
      step(1);
    end
    mem_busy = 1'b0;
    #1;
    check("stall_end_strobes", 32'(strobes), 32'b001);
    check("stall_end_hold",    32'(pc_hold), 32'd0);
    check("stall_end_count",   32'(instr_count), 32'd1);
    step(3);
    check("stall_count", 32'(instr_count), 32'd2);
    check("stall_error", 32'(error), 32'd0);
    check("stall_done",  32'(done), 32'd1);
    check("stall_pc",    32'(pc), 32'd4);

    // Stuck mem_busy: abort on the 16th busy cycle
    clear_rom();
    rom[10] = 9'h1FF;
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    mem_busy = 1'b1;
    step(15);
    check("abort_pre_error",   32'(error), 32'd0);
    check("abort_pre_running", 32'(running), 32'd1);
    check("abort_pre_hold",    32'(pc_hold), 32'd1);
    step(1);
    check("abort_error",   32'(error), 32'd1);
    check("abort_done",    32'(done), 32'd1);
    check("abort_running", 32'(running), 32'd0);
    check("abort_count",   32'(instr_count), 32'd0);
    mem_busy = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    check("reboot_error",    32'(error), 32'd0);
    check("reboot_done",     32'(done), 32'd0);
    check("reboot_pc_reset", 32'(pc_reset), 32'd1);
    step(1);
    check("reboot_pc",      32'(pc), 32'd0);
    check("reboot_running", 32'(running), 32'd1);

    // Reset dropped during STALL
    step(2);
    mem_busy = 1'b1;
    step(1);
    check("mid_running", 32'(running), 32'd1);
    check("mid_count",   32'(instr_count), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_count",   32'(instr_count), 32'd0);
    check("mid_rst_hold",    32'(pc_hold), 32'd1);
    check("mid_rst_done",    32'(done), 32'd0);
    step(1);
    reset = 1'b1; mem_busy = 1'b0;
    step(1);

    // start pulse while in RUN is ignored
    snapshot();
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    step(8);
    check("ign_pc_reset_pulses", 32'(n_pc_reset - base_pr), 32'd1);
    check("ign_count", 32'(instr_count), 32'd10);
    check("ign_done",  32'(done), 32'd1);
    check("ign_pc",    32'(pc), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
